tilemapsr_multi: RTL and testbench
==================================

Name: tilemapsr_multi

Overview:
- Parametrised N-layer tilemap pixel shift-register array for the gfx pipeline.
- Per layer: captures one packed tile line from the shared graphics data bus into a line latch, then parallel-loads or shifts it in either direction.
- Selects a flip-dependent output tap and passes it through a run-time programmable pixel delay line.
- Flags transparency per pixel; tracks latch underrun/overrun per layer with sticky error bits.

Parameters:
LAYERS, 2, number of independent tilemap layers
BPP, 4, bits per pixel
TILE_W, 8, pixels per tile line; the bus is TILE_W*BPP bits wide
DELAY_MAX, 7, maximum programmable output delay in pixel clocks (>=1)

Ports:
i_EMU_MCLK  in  1  master clock
i_EMU_RST_n  in  1  synchronous active-low reset
i_EMU_CLK6MPCEN_n  in  1  active-low pixel clock enable; all state advances only when low
i_GFXDATA  in  TILE_W*BPP  shared tile line data; pixel0 is in the MSBs
i_LATCH_EN  in  LAYERS  per-layer line latch capture strobe
i_MODE  in  2*LAYERS  per-layer SR mode; layer l uses bits [2l+1:2l]
i_FLIP  in  LAYERS  per-layer horizontal flip (tap select)
i_DELAY  in  LAYERS*clog2(DELAY_MAX+1)  per-layer output delay, 0..DELAY_MAX
i_ERR_CLR  in  LAYERS  per-layer sticky error clear
o_PIXEL  out  LAYERS*BPP  per-layer pixel output
o_TRN_n  out  LAYERS  low = transparent (pixel == 0)
o_UNDERRUN  out  LAYERS  sticky: LOAD issued with no fresh latch data
o_OVERRUN  out  LAYERS  sticky: latch recaptured before it was consumed

Behaviour:
- Reset: synchronous, active-low. Takes priority over the clock enable and clears everything: latches, SR cells, delay stages, valid bits and error bits. After reset, o_PIXEL = 0, o_TRN_n = 0, error flags = 0.
- All updates below occur on a rising i_EMU_MCLK edge with i_EMU_CLK6MPCEN_n = 0. Otherwise every state bit holds.
- Latch capture: i_LATCH_EN[l] = 1 copies i_GFXDATA into LATCH[l] and sets VALID[l].
- Mode 00, hold: SR unchanged.
- Mode 01, shift right: P[k] <= P[k-1] for k >= 1; P[0] <= 0.
- Mode 10, shift left: P[k] <= P[k+1] for k < TILE_W-1; P[TILE_W-1] <= 0.
- Mode 11, load: P[k] <= LATCH[l] pixel k, where pixel k is bits [(TILE_W-k)*BPP-1 -: BPP]. Clears VALID[l].
- Load with VALID[l] = 0: load still executes using the stale latch contents, and o_UNDERRUN[l] is set.
- Capture with VALID[l] = 1 and no load in the same cycle: o_OVERRUN[l] is set.
- Capture and load in the same cycle: the load uses the pre-capture latch contents; the new data is captured; VALID ends at 1; no overrun. Underrun is still evaluated against the pre-cycle VALID.
- Error clear: i_ERR_CLR[l] clears both flags for layer l. If a new error event occurs in the same cycle, the set wins.
- Tap: TAP = i_FLIP ? P[TILE_W-1] : P[0]. Combinational from SR state.
- Delay line: DELAY_MAX registered stages, D1 <= TAP, Dn <= Dn-1.
  - o_PIXEL = TAP when i_DELAY = 0; otherwise D[i_DELAY].
  - Total latency from an SR update is i_DELAY enable cycles; delay 0 means output changes in the same cycle the SR updates.
  - A change to i_DELAY takes effect immediately (mux only, no flush); pixels may repeat or skip.
  - i_DELAY > DELAY_MAX is clamped to DELAY_MAX.
- o_TRN_n[l] = OR-reduce of o_PIXEL[l]. Combinational.
- Layers are fully independent; no cross-layer interaction.

Decomposition:
- Package tilemapsr_pkg holds:
  - mode constants SR_HOLD = 2'b00, SR_SHR = 2'b01, SR_SHL = 2'b10, SR_LOAD = 2'b11
  - a function for the delay select width, clog2(DELAY_MAX+1)
- Sub-module tilemapsr_lane implements one layer: latch, VALID, SR, tap, delay line and error flags.
- The top level is a generate loop over LAYERS plus bus slicing.

Test Plan:
1. Reset then idle: hold i_EMU_RST_n = 0 for 2 enabled clocks -> o_PIXEL = 0, o_TRN_n = 0, all flags 0. Repeat with CEN high during reset -> same result.
2. Normal left shift, layer 0, FLIP = 0, DELAY = 0: latch 32'h1234_5678, LOAD, then 8 x SHL -> o_PIXEL sequence 1,2,3,4,5,6,7,8, then 0; o_TRN_n falls on the 0.
3. Flipped right shift, FLIP = 1, DELAY = 3: latch 32'h1234_5678, LOAD, then SHR -> output 8,7,6,...,1 appearing 3 enabled clocks after each SR update. CEN held high for 2 clocks mid-sequence -> output stalls and no pixel is lost.
4. Errors: LOAD with no prior latch -> UNDERRUN = 1. Two captures without a load -> OVERRUN = 1. ERR_CLR asserted in the same cycle as a new overrun -> flag remains 1. ERR_CLR alone -> flag = 0.
5. Simultaneous events: latch A = 32'hAAAA_AAAA, then capture B = 32'h5555_5555 together with LOAD -> SR holds A pixels, next LOAD yields B with no underrun and no overrun.
6. Layer independence and parameters: LAYERS = 3, BPP = 2, TILE_W = 16, DELAY_MAX = 4, with different modes and delays per layer -> each layer matches the reference model. i_DELAY = 7 behaves as delay 4.

Source files
------------

// File: rtl/tilemapsr_pkg.sv
// Shared constants and helpers for the tilemap shift-register array.
package tilemapsr_pkg;

   localparam logic [1:0] SR_HOLD = 2'b00;
   localparam logic [1:0] SR_SHR  = 2'b01;
   localparam logic [1:0] SR_SHL  = 2'b10;
   localparam logic [1:0] SR_LOAD = 2'b11;

   // Width of a per-layer delay select able to encode 0..dmax.
   function automatic int unsigned dsel_w(input int unsigned dmax);
      return $clog2(dmax + 1);
   endfunction

endpackage

// File: rtl/tilemapsr_if.sv
// Control/data bundle between the gfx pipeline and the tilemap SR array.
interface tilemapsr_if
   import tilemapsr_pkg::*;
#(
   parameter int unsigned LAYERS    = 2,
   parameter int unsigned BPP       = 4,
   parameter int unsigned TILE_W    = 8,
   parameter int unsigned DELAY_MAX = 7
);
   localparam int unsigned DW = dsel_w(DELAY_MAX);
   localparam int unsigned GW = TILE_W * BPP;

   logic                     i_EMU_CLK6MPCEN_n;
   logic [GW-1:0]            i_GFXDATA;
   logic [LAYERS-1:0]        i_LATCH_EN;
   logic [2*LAYERS-1:0]      i_MODE;
   logic [LAYERS-1:0]        i_FLIP;
   logic [LAYERS*DW-1:0]     i_DELAY;
   logic [LAYERS-1:0]        i_ERR_CLR;
   logic [LAYERS*BPP-1:0]    o_PIXEL;
   logic [LAYERS-1:0]        o_TRN_n;
   logic [LAYERS-1:0]        o_UNDERRUN;
   logic [LAYERS-1:0]        o_OVERRUN;

   modport master (
      output i_EMU_CLK6MPCEN_n, i_GFXDATA, i_LATCH_EN, i_MODE, i_FLIP, i_DELAY, i_ERR_CLR,
      input  o_PIXEL, o_TRN_n, o_UNDERRUN, o_OVERRUN
   );

   modport slave (
      input  i_EMU_CLK6MPCEN_n, i_GFXDATA, i_LATCH_EN, i_MODE, i_FLIP, i_DELAY, i_ERR_CLR,
      output o_PIXEL, o_TRN_n, o_UNDERRUN, o_OVERRUN
   );

endinterface

// File: rtl/tilemapsr_lane.sv
// One tilemap layer: line latch, pixel shift register, flip tap, delay line, error flags.
module tilemapsr_lane
   import tilemapsr_pkg::*;
#(
   parameter int unsigned BPP       = 4,
   parameter int unsigned TILE_W    = 8,
   parameter int unsigned DELAY_MAX = 7,
   parameter int unsigned DW        = dsel_w(DELAY_MAX)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cen_n,
   input  logic [TILE_W*BPP-1:0] gfxdata,
   input  logic                  latch_en,
   input  logic [1:0]            mode,
   input  logic                  flip,
   input  logic [DW-1:0]         delay,
   input  logic                  err_clr,
   output logic [BPP-1:0]        pixel,
   output logic                  trn_n,
   output logic                  underrun,
   output logic                  overrun
);
   localparam int unsigned GW = TILE_W * BPP;

   logic [GW-1:0]                     latch_q;
   logic                              valid_q;
   logic [TILE_W-1:0][BPP-1:0]        sr_q;
   logic [TILE_W-1:0][BPP-1:0]        sr_d;
   logic [DELAY_MAX-1:0][BPP-1:0]     dly_q;
   logic [BPP-1:0]                    tap;
   logic [DW-1:0]                     dsel;
   logic                              load;

   assign load = (mode == SR_LOAD);

   // Next shift-register contents; a load reads the latch as it was before this cycle's capture.
   always_comb begin
      sr_d = sr_q;
      case (mode)
         SR_SHR:  sr_d = {sr_q[TILE_W-2:0], BPP'(0)};
         SR_SHL:  sr_d = {BPP'(0), sr_q[TILE_W-1:1]};
         SR_LOAD: begin
            for (int k = 0; k < TILE_W; k++) begin
               sr_d[k] = latch_q[(TILE_W-1-k)*BPP +: BPP];
            end
         end
         default: sr_d = sr_q;
      endcase
   end

   assign tap  = flip ? sr_q[TILE_W-1] : sr_q[0];
   assign dsel = (32'(delay) > DELAY_MAX) ? DW'(DELAY_MAX) : delay;

   // Output tap selection: delay 0 bypasses the delay line entirely.
   always_comb begin
      pixel = tap;
      for (int n = 1; n <= DELAY_MAX; n++) begin
         if (dsel == DW'(n)) pixel = dly_q[n-1];
      end
   end

   assign trn_n = |pixel;

   // Latch, SR, delay line and sticky flags; everything advances only on enabled pixel clocks.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         latch_q  <= '0;
         valid_q  <= 1'b0;
         sr_q     <= '0;
         dly_q    <= '0;
         underrun <= 1'b0;
         overrun  <= 1'b0;
      end else if (!cen_n) begin
         if (latch_en) latch_q <= gfxdata;
         valid_q  <= latch_en | (valid_q & ~load);
         sr_q     <= sr_d;
         dly_q[0] <= tap;
         for (int n = 1; n < DELAY_MAX; n++) begin
            dly_q[n] <= dly_q[n-1];
         end
         underrun <= (load & ~valid_q) | (underrun & ~err_clr);
         overrun  <= (latch_en & valid_q & ~load) | (overrun & ~err_clr);
      end
   end

endmodule

// File: rtl/tilemapsr_multi.sv
// N-layer tilemap pixel shift-register array; one independent lane per layer.
module tilemapsr_multi
   import tilemapsr_pkg::*;
#(
   parameter int unsigned LAYERS    = 2,
   parameter int unsigned BPP       = 4,
   parameter int unsigned TILE_W    = 8,
   parameter int unsigned DELAY_MAX = 7
) (
   input  logic        i_EMU_MCLK,
   input  logic        i_EMU_RST_n,
   tilemapsr_if.slave  bus
);
   localparam int unsigned DW = dsel_w(DELAY_MAX);

   // Slice the shared bus into per-layer lanes.
   for (genvar l = 0; l < LAYERS; l++) begin : g_lane
      tilemapsr_lane #(
         .BPP       (BPP),
         .TILE_W    (TILE_W),
         .DELAY_MAX (DELAY_MAX),
         .DW        (DW)
      ) u_lane (
         .clk       (i_EMU_MCLK),
         .rst_n     (i_EMU_RST_n),
         .cen_n     (bus.i_EMU_CLK6MPCEN_n),
         .gfxdata   (bus.i_GFXDATA),
         .latch_en  (bus.i_LATCH_EN[l]),
         .mode      (bus.i_MODE[2*l +: 2]),
         .flip      (bus.i_FLIP[l]),
         .delay     (bus.i_DELAY[DW*l +: DW]),
         .err_clr   (bus.i_ERR_CLR[l]),
         .pixel     (bus.o_PIXEL[BPP*l +: BPP]),
         .trn_n     (bus.o_TRN_n[l]),
         .underrun  (bus.o_UNDERRUN[l]),
         .overrun   (bus.o_OVERRUN[l])
      );
   end

endmodule

// File: tb/tb_tilemapsr_multi.sv
// Bench for tilemapsr_multi: two configurations checked against a history-based model.
module tb_tilemapsr_multi;

   logic clk;
   logic rst_n;
   bit   chk_en;
   int   n_tests;
   int   n_fail;

   // Config 0: 2 layers, 4bpp, 8 px, delay 7. Config 1: 3 layers, 2bpp, 16 px, delay 4.
   int nl [2] = '{2, 3};
   int nb [2] = '{4, 2};
   int nw [2] = '{8, 16};
   int dm [2] = '{7, 4};

   logic        cen_n [2];
   logic [31:0] gfx   [2];
   logic        len   [2][3];
   logic        flp   [2][3];
   logic        clr   [2][3];
   logic [1:0]  mde   [2][3];
   logic [2:0]  dly   [2][3];

   logic [31:0] m_lat  [2][3];
   bit          m_val  [2][3];
   bit          m_und  [2][3];
   bit          m_ovr  [2][3];
   int          m_sr   [2][3][16];
   int          m_hist [2][3][8];
   int          m_tap;
   bit          m_ld;

   int t3_exp [12] = '{0, 0, 0, 8, 7, 6, 5, 4, 3, 2, 1, 0};
   int t6_exp [9]  = '{0, 0, 0, 0, 0, 1, 2, 3, 0};

   tilemapsr_if #(.LAYERS(2), .BPP(4), .TILE_W(8),  .DELAY_MAX(7)) ifa ();
   tilemapsr_if #(.LAYERS(3), .BPP(2), .TILE_W(16), .DELAY_MAX(4)) ifb ();

   tilemapsr_multi #(.LAYERS(2), .BPP(4), .TILE_W(8), .DELAY_MAX(7)) u_dut_a (
      .i_EMU_MCLK  (clk),
      .i_EMU_RST_n (rst_n),
      .bus         (ifa)
   );

   tilemapsr_multi #(.LAYERS(3), .BPP(2), .TILE_W(16), .DELAY_MAX(4)) u_dut_b (
      .i_EMU_MCLK  (clk),
      .i_EMU_RST_n (rst_n),
      .bus         (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pack bench stimulus variables onto both interfaces.
   always_comb begin
      ifa.i_EMU_CLK6MPCEN_n = cen_n[0];
      ifa.i_GFXDATA         = gfx[0];
      ifa.i_LATCH_EN        = '0;
      ifa.i_MODE            = '0;
      ifa.i_FLIP            = '0;
      ifa.i_DELAY           = '0;
      ifa.i_ERR_CLR         = '0;
      for (int l = 0; l < 2; l++) begin
         ifa.i_LATCH_EN[l]    = len[0][l];
         ifa.i_MODE[2*l +: 2] = mde[0][l];
         ifa.i_FLIP[l]        = flp[0][l];
         ifa.i_DELAY[3*l +: 3] = dly[0][l];
         ifa.i_ERR_CLR[l]     = clr[0][l];
      end
      ifb.i_EMU_CLK6MPCEN_n = cen_n[1];
      ifb.i_GFXDATA         = gfx[1];
      ifb.i_LATCH_EN        = '0;
      ifb.i_MODE            = '0;
      ifb.i_FLIP            = '0;
      ifb.i_DELAY           = '0;
      ifb.i_ERR_CLR         = '0;
      for (int l = 0; l < 3; l++) begin
         ifb.i_LATCH_EN[l]    = len[1][l];
         ifb.i_MODE[2*l +: 2] = mde[1][l];
         ifb.i_FLIP[l]        = flp[1][l];
         ifb.i_DELAY[3*l +: 3] = dly[1][l];
         ifb.i_ERR_CLR[l]     = clr[1][l];
      end
   end

   function automatic int dpix(input int c, input int l);
      if (c == 0) return int'((ifa.o_PIXEL >> (4*l)) & 8'hF);
      return int'((ifb.o_PIXEL >> (2*l)) & 6'h3);
   endfunction

   function automatic int dtrn(input int c, input int l);
      if (c == 0) return int'(ifa.o_TRN_n[l]);
      return int'(ifb.o_TRN_n[l]);
   endfunction

   function automatic int dund(input int c, input int l);
      if (c == 0) return int'(ifa.o_UNDERRUN[l]);
      return int'(ifb.o_UNDERRUN[l]);
   endfunction

   function automatic int dovr(input int c, input int l);
      if (c == 0) return int'(ifa.o_OVERRUN[l]);
      return int'(ifb.o_OVERRUN[l]);
   endfunction

   function automatic int mtap(input int c, input int l);
      return flp[c][l] ? m_sr[c][l][nw[c]-1] : m_sr[c][l][0];
   endfunction

   // Expected pixel: current tap, or the tap as it stood d enabled clocks ago.
   function automatic int mpix(input int c, input int l);
      int d;
      d = int'(dly[c][l]);
      if (d > dm[c]) d = dm[c];
      return (d == 0) ? mtap(c, l) : m_hist[c][l][d-1];
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference model: pixels as plain integers, delay line as a history of past taps.
   always @(posedge clk) begin
      for (int c = 0; c < 2; c++) begin
         for (int l = 0; l < nl[c]; l++) begin
            if (!rst_n) begin
               m_lat[c][l] = '0;
               m_val[c][l] = 1'b0;
               m_und[c][l] = 1'b0;
               m_ovr[c][l] = 1'b0;
               for (int k = 0; k < 16; k++) m_sr[c][l][k] = 0;
               for (int k = 0; k < 8; k++) m_hist[c][l][k] = 0;
            end else if (!cen_n[c]) begin
               m_tap = mtap(c, l);
               for (int j = 7; j > 0; j--) m_hist[c][l][j] = m_hist[c][l][j-1];
               m_hist[c][l][0] = m_tap;
               m_ld = (mde[c][l] == 2'b11);
               m_und[c][l] = (m_ld && !m_val[c][l]) || (m_und[c][l] && !clr[c][l]);
               m_ovr[c][l] = (len[c][l] && m_val[c][l] && !m_ld) || (m_ovr[c][l] && !clr[c][l]);
               case (mde[c][l])
                  2'b01: begin
                     for (int k = nw[c]-1; k > 0; k--) m_sr[c][l][k] = m_sr[c][l][k-1];
                     m_sr[c][l][0] = 0;
                  end
                  2'b10: begin
                     for (int k = 0; k < nw[c]-1; k++) m_sr[c][l][k] = m_sr[c][l][k+1];
                     m_sr[c][l][nw[c]-1] = 0;
                  end
                  2'b11: begin
                     for (int k = 0; k < nw[c]; k++)
                        m_sr[c][l][k] = int'(m_lat[c][l] >> ((nw[c]-1-k)*nb[c])) & ((1 << nb[c]) - 1);
                  end
                  default: ;
               endcase
               if (len[c][l]) begin
                  m_lat[c][l] = gfx[c];
                  m_val[c][l] = 1'b1;
               end else if (m_ld) begin
                  m_val[c][l] = 1'b0;
               end
            end
         end
      end
   end

   // Every-cycle comparison of all layers of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int c = 0; c < 2; c++) begin
            for (int l = 0; l < nl[c]; l++) begin
               chk($sformatf("c%0d_l%0d_pixel", c, l), dpix(c, l), mpix(c, l));
               chk($sformatf("c%0d_l%0d_trn_n", c, l), dtrn(c, l), int'(mpix(c, l) != 0));
               chk($sformatf("c%0d_l%0d_underrun", c, l), dund(c, l), int'(m_und[c][l]));
               chk($sformatf("c%0d_l%0d_overrun", c, l), dovr(c, l), int'(m_ovr[c][l]));
            end
         end
      end
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      chk_en  = 1'b0;
      rst_n   = 1'b0;
      for (int c = 0; c < 2; c++) begin
         cen_n[c] = 1'b0;
         gfx[c]   = '0;
         for (int l = 0; l < 3; l++) begin
            len[c][l] = 1'b0;
            flp[c][l] = 1'b0;
            clr[c][l] = 1'b0;
            mde[c][l] = 2'b00;
            dly[c][l] = 3'd0;
         end
      end

      // Reset with the pixel clock enabled.
      repeat (2) cyc();
      for (int c = 0; c < 2; c++) begin
         for (int l = 0; l < nl[c]; l++) begin
            chk("rst_pixel", dpix(c, l), 0);
            chk("rst_trn_n", dtrn(c, l), 0);
            chk("rst_underrun", dund(c, l), 0);
            chk("rst_overrun", dovr(c, l), 0);
         end
      end
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // Build up state (pixel F on layer 0, underrun on layer 1), then reset with CEN high.
      gfx[0] = 32'hFFFF_FFFF;
      len[0][0] = 1'b1;
      cyc();
      len[0][0] = 1'b0;
      mde[0][0] = 2'b11;
      mde[0][1] = 2'b11;
      cyc();
      mde[0][0] = 2'b00;
      mde[0][1] = 2'b00;
      chk("pre_rst_pixel", dpix(0, 0), 15);
      chk("pre_rst_underrun", dund(0, 1), 1);
      cen_n[0] = 1'b1;
      cen_n[1] = 1'b1;
      rst_n    = 1'b0;
      repeat (2) cyc();
      chk("rst_cen_pixel", dpix(0, 0), 0);
      chk("rst_cen_trn_n", dtrn(0, 0), 0);
      chk("rst_cen_underrun", dund(0, 1), 0);
      rst_n    = 1'b1;
      cen_n[0] = 1'b0;
      cen_n[1] = 1'b0;

      // Left shift, no flip, no delay.
      gfx[0] = 32'h1234_5678;
      len[0][0] = 1'b1;
      cyc();
      len[0][0] = 1'b0;
      mde[0][0] = 2'b11;
      cyc();
      chk("shl_pixel", dpix(0, 0), 1);
      mde[0][0] = 2'b10;
      for (int n = 1; n <= 8; n++) begin
         cyc();
         chk("shl_pixel", dpix(0, 0), (n == 8) ? 0 : n + 1);
         chk("shl_trn_n", dtrn(0, 0), (n == 8) ? 0 : 1);
      end
      mde[0][0] = 2'b00;

      // Flipped right shift through a 3-stage delay with a 2-clock enable stall.
      flp[0][0] = 1'b1;
      dly[0][0] = 3'd3;
      len[0][0] = 1'b1;
      cyc();
      len[0][0] = 1'b0;
      repeat (3) cyc();
      mde[0][0] = 2'b11;
      cyc();
      chk("shr_dly_pixel", dpix(0, 0), t3_exp[0]);
      mde[0][0] = 2'b01;
      for (int n = 1; n < 12; n++) begin
         if (n == 6) begin
            cen_n[0] = 1'b1;
            repeat (2) begin
               cyc();
               chk("stall_pixel", dpix(0, 0), t3_exp[5]);
            end
            cen_n[0] = 1'b0;
         end
         cyc();
         chk("shr_dly_pixel", dpix(0, 0), t3_exp[n]);
      end
      mde[0][0] = 2'b00;

      // Error flags on layer 1.
      mde[0][1] = 2'b11;
      cyc();
      chk("underrun_set", dund(0, 1), 1);
      mde[0][1] = 2'b00;
      len[0][1] = 1'b1;
      cyc();
      chk("overrun_first_capture", dovr(0, 1), 0);
      cyc();
      chk("overrun_set", dovr(0, 1), 1);
      clr[0][1] = 1'b1;
      cyc();
      chk("overrun_set_beats_clr", dovr(0, 1), 1);
      len[0][1] = 1'b0;
      cyc();
      chk("clr_overrun", dovr(0, 1), 0);
      chk("clr_underrun", dund(0, 1), 0);
      clr[0][1] = 1'b0;

      // Capture and load in the same cycle.
      mde[0][1] = 2'b11;
      cyc();
      mde[0][1] = 2'b00;
      gfx[0] = 32'hAAAA_AAAA;
      len[0][1] = 1'b1;
      cyc();
      gfx[0] = 32'h5555_5555;
      mde[0][1] = 2'b11;
      cyc();
      chk("simul_pixel_a", dpix(0, 1), 10);
      chk("simul_underrun", dund(0, 1), 0);
      chk("simul_overrun", dovr(0, 1), 0);
      len[0][1] = 1'b0;
      cyc();
      chk("simul_pixel_b", dpix(0, 1), 5);
      chk("simul_underrun2", dund(0, 1), 0);
      chk("simul_overrun2", dovr(0, 1), 0);
      mde[0][1] = 2'b00;

      // Second configuration: delay select 7 clamps to 4.
      dly[1][0] = 3'd7;
      gfx[1] = 32'h1B00_0000;
      len[1][0] = 1'b1;
      cyc();
      len[1][0] = 1'b0;
      repeat (4) cyc();
      mde[1][0] = 2'b11;
      cyc();
      chk("clamp_pixel", dpix(1, 0), t6_exp[0]);
      mde[1][0] = 2'b10;
      for (int n = 1; n < 9; n++) begin
         cyc();
         chk("clamp_pixel", dpix(1, 0), t6_exp[n]);
      end

      // Mixed per-layer modes, delays, flips, captures, clears and stalls.
      for (int i = 0; i < 48; i++) begin
         gfx[1]   = $urandom;
         cen_n[1] = (i % 7 == 3);
         for (int l = 0; l < 3; l++) begin
            len[1][l] = ((i + l) % 3 == 0);
            mde[1][l] = 2'((i * (l + 1) + l) % 4);
            flp[1][l] = (l != 1);
            clr[1][l] = (i % 11 == l);
            dly[1][l] = (l == 0) ? 3'd7 : (l == 1) ? 3'(i / 16) : 3'd2;
         end
         cyc();
      end
      cen_n[1] = 1'b0;
      repeat (4) cyc();

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
